pipe_reg_de: RTL and testbench
==============================

Name: pipe_reg_de

Overview:
- Parametrised decode-to-execute pipeline register for the pipelined RV32 core.
- Carries NUM_DATA data lanes, a control bundle, and register-address fields from D to E in one registered stage.
- Adds stall (hold), flush (bubble insert), valid tracking, bubble normalisation and asynchronous reset.
- Sits between the register file/immediate extender and the ALU/forwarding muxes; driven by the hazard unit.

Parameters:
- DATA_WIDTH, 32, width of each data lane
- NUM_DATA, 5, number of data lanes; lane order 0..4 = RD1, RD2, PC, ImmExt, PCPlus4
- CTRL_WIDTH, 12, width of packed control bundle (RegWrite, MemWrite, Jump, Branch, ALUControl, ALUSrc, ResultSrc)
- REG_ADDR_WIDTH, 5, register address width
- CNT_WIDTH, 32, performance counter width (optional feature)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  1 = advance (capture D inputs), 0 = stall (hold)
- flush  in  1  insert bubble on next edge; has priority over en
- valid_d  in  1  D-stage instruction valid
- ctrl_d  in  CTRL_WIDTH  D-stage control bundle
- rd_d, rs1_d, rs2_d  in  REG_ADDR_WIDTH each  destination and source register addresses
- data_d  in  NUM_DATA*DATA_WIDTH  packed lanes; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- valid_e  out  1  E-stage valid
- ctrl_e  out  CTRL_WIDTH  E-stage control
- rd_e, rs1_e, rs2_e  out  REG_ADDR_WIDTH each  E-stage register addresses
- data_e  out  NUM_DATA*DATA_WIDTH  E-stage data lanes
- stall_cnt  out  CNT_WIDTH  held-valid-instruction cycle count (optional feature)
- flush_cnt  out  CNT_WIDTH  flush cycle count (optional feature)

Behaviour:
- Reset: rst_n low forces all outputs to 0 immediately, independent of clk. Counters also reset to 0.
- Reset release: no capture until the first rising edge with rst_n high. Reset asserted mid-operation discards the in-flight instruction.
- Latency: 1 cycle D to E when en=1 and flush=0.
- Priority at each rising edge (rst_n high):
  1) flush=1: valid_e=0; ctrl_e, rd_e, rs1_e, rs2_e, data_e all set to 0. Applies regardless of en (flush during stall still clears).
  2) flush=0, en=1: capture all D inputs.
  3) flush=0, en=0: hold every output unchanged.
- Bubble normalisation: on capture with valid_d=0, ctrl_e and rd_e are forced to 0 so no RegWrite, MemWrite, branch or forwarding match is possible. rs1_e, rs2_e and data_e still capture.
- No combinational path from any input to any output.
- A stall holds its state indefinitely with no timeout.

Optional Feature:
- Macro: PIPE_REG_DE_PERF_EN
- Defined: stall_cnt increments on each edge with flush=0, en=0, valid_e=1; flush_cnt increments on each edge with flush=1. Both saturate at all-ones (no wrap) and reset asynchronously to 0.
- Not defined: stall_cnt and flush_cnt are tied to constant 0 and no counter flops are built. Ports remain so integration is identical.

Test Plan:
- Reset: drive nonzero inputs, pulse rst_n low between clock edges -> all outputs 0 immediately. After release, first edge with en=1 captures, e.g. data lane 2 (PC) = 0x0000_0010.
- Advance: en=1, flush=0, valid_d=1, ctrl_d=0xA5, rd_d=7, lane0=0xDEAD_BEEF -> one edge later valid_e=1, ctrl_e=0xA5, rd_e=7, lane0=0xDEAD_BEEF.
- Stall: capture the above, then en=0 for 3 edges while D inputs change to 0x1234_5678 -> outputs keep 0xDEAD_BEEF and rd_e=7. With macro defined, stall_cnt=3.
- Flush priority: en=0 and flush=1 on the same edge -> valid_e=0, ctrl_e=0, rd_e=0, data_e=0. With macro, flush_cnt=1 and stall_cnt unchanged.
- Bubble normalisation: en=1, valid_d=0, ctrl_d=0xFFF, rd_d=31, rs1_d=4, lane1=0x55 -> valid_e=0, ctrl_e=0, rd_e=0, rs1_e=4, lane1=0x55.
- Saturation (macro defined, CNT_WIDTH=4): hold flush=1 for 20 edges -> flush_cnt stops at 15 and stays there.

Source files
------------

// File: rtl/pipe_reg_de.sv
// Decode-to-execute pipeline register: stall hold, flush bubble, bubble normalisation.
// Optional stall/flush performance counters are built only when PIPE_REG_DE_PERF_EN is defined.
module pipe_reg_de #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_DATA       = 5,
  parameter int CTRL_WIDTH     = 12,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           flush,
  input  logic                           valid_d,
  input  logic [CTRL_WIDTH-1:0]          ctrl_d,
  input  logic [REG_ADDR_WIDTH-1:0]      rd_d,
  input  logic [REG_ADDR_WIDTH-1:0]      rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0]      rs2_d,
  input  logic [NUM_DATA*DATA_WIDTH-1:0] data_d,
  output logic                           valid_e,
  output logic [CTRL_WIDTH-1:0]          ctrl_e,
  output logic [REG_ADDR_WIDTH-1:0]      rd_e,
  output logic [REG_ADDR_WIDTH-1:0]      rs1_e,
  output logic [REG_ADDR_WIDTH-1:0]      rs2_e,
  output logic [NUM_DATA*DATA_WIDTH-1:0] data_e,
  output logic [CNT_WIDTH-1:0]           stall_cnt,
  output logic [CNT_WIDTH-1:0]           flush_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e <= 1'b0;
      ctrl_e  <= '0;
      rd_e    <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      data_e  <= '0;
    end else if (flush) begin
      valid_e <= 1'b0;
      ctrl_e  <= '0;
      rd_e    <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      data_e  <= '0;
    end else if (en) begin
      valid_e <= valid_d;
      // A bubble must never write state or match a forwarding compare.
      ctrl_e  <= valid_d ? ctrl_d : '0;
      rd_e    <= valid_d ? rd_d : '0;
      rs1_e   <= rs1_d;
      rs2_e   <= rs2_d;
      data_e  <= data_d;
    end
  end

`ifdef PIPE_REG_DE_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] flush_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (flush && (flush_q != '1))
        flush_q <= flush_q + CNT_ONE;
      if (!flush && !en && valid_e && (stall_q != '1))
        stall_q <= stall_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_de.sv
// Directed bench for pipe_reg_de; counter checks follow PIPE_REG_DE_PERF_EN.
module tb_pipe_reg_de;
  localparam int DW = 32;
  localparam int ND = 5;
  localparam int CW = 12;
  localparam int AW = 5;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          flush;
  logic          valid_d;
  logic [CW-1:0] ctrl_d;
  logic [AW-1:0] rd_d, rs1_d, rs2_d;
  logic [ND*DW-1:0] data_d;
  logic          valid_e;
  logic [CW-1:0] ctrl_e;
  logic [AW-1:0] rd_e, rs1_e, rs2_e;
  logic [ND*DW-1:0] data_e;
  logic [NW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipe_reg_de #(
    .DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW),
    .REG_ADDR_WIDTH(AW), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_d(valid_d),
    .ctrl_d(ctrl_d), .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .data_d(data_d),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .data_e(data_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ND*DW-1:0] got, input logic [ND*DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] lane(input int idx);
    return data_e[idx*DW +: DW];
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; valid_d = 1'b0;
    ctrl_d = '0; rd_d = '0; rs1_d = '0; rs2_d = '0; data_d = '0;
    step(2);
    rst_n = 1'b1;

    // capture something nonzero, then reset between edges
    en = 1'b1; valid_d = 1'b1; ctrl_d = 12'h3C; rd_d = 5'd3; rs1_d = 5'd1; rs2_d = 5'd2;
    data_d = {ND*DW{1'b1}};
    step(1);
    check("pre_rst_valid", valid_e, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", valid_e, 0);
    check("rst_ctrl", ctrl_e, 0);
    check("rst_rd", rd_e, 0);
    check("rst_rs", {rs1_e, rs2_e}, 0);
    check("rst_data", data_e, 0);
    check("rst_cnt", {stall_cnt, flush_cnt}, 0);
    #1 rst_n = 1'b1;
    #1;
    check("rel_no_capture", valid_e, 0);

    data_d = '0; data_d[2*DW +: DW] = 32'h0000_0010;
    step(1);
    check("first_pc", lane(2), 32'h0000_0010);
    check("first_valid", valid_e, 1);

    // advance
    ctrl_d = 12'h0A5; rd_d = 5'd7; rs1_d = 5'd3; rs2_d = 5'd9;
    data_d = '0; data_d[0 +: DW] = 32'hDEAD_BEEF;
    step(1);
    check("adv_valid", valid_e, 1);
    check("adv_ctrl", ctrl_e, 12'h0A5);
    check("adv_rd", rd_e, 7);
    check("adv_rs", {rs1_e, rs2_e}, {5'd3, 5'd9});
    check("adv_lane0", lane(0), 32'hDEAD_BEEF);

    // stall for 3 edges while D changes
    en = 1'b0; valid_d = 1'b0; ctrl_d = 12'h111; rd_d = 5'd9;
    data_d = {ND{32'h1234_5678}};
    step(3);
    check("stall_lane0", lane(0), 32'hDEAD_BEEF);
    check("stall_rd", rd_e, 7);
    check("stall_valid", valid_e, 1);
    check("stall_ctrl", ctrl_e, 12'h0A5);
`ifdef PIPE_REG_DE_PERF_EN
    check("stall_cnt3", stall_cnt, 3);
    check("flush_cnt0", flush_cnt, 0);
`else
    check("stall_cnt_off", stall_cnt, 0);
`endif

    // flush wins over stall
    flush = 1'b1;
    step(1);
    check("fl_valid", valid_e, 0);
    check("fl_ctrl", ctrl_e, 0);
    check("fl_rd", rd_e, 0);
    check("fl_rs", {rs1_e, rs2_e}, 0);
    check("fl_data", data_e, 0);
`ifdef PIPE_REG_DE_PERF_EN
    check("fl_flush_cnt", flush_cnt, 1);
    check("fl_stall_cnt", stall_cnt, 3);
`else
    check("flush_cnt_off", flush_cnt, 0);
`endif

    // stall with an invalid E instruction is not counted
    flush = 1'b0;
    step(2);
    check("idle_valid", valid_e, 0);
`ifdef PIPE_REG_DE_PERF_EN
    check("idle_stall_cnt", stall_cnt, 3);
`endif

    // bubble normalisation
    en = 1'b1; valid_d = 1'b0; ctrl_d = 12'hFFF; rd_d = 5'd31; rs1_d = 5'd4; rs2_d = 5'd6;
    data_d = '0; data_d[1*DW +: DW] = 32'h55;
    step(1);
    check("bub_valid", valid_e, 0);
    check("bub_ctrl", ctrl_e, 0);
    check("bub_rd", rd_e, 0);
    check("bub_rs1", rs1_e, 4);
    check("bub_rs2", rs2_e, 6);
    check("bub_lane1", lane(1), 32'h55);

    // resume with a valid instruction
    valid_d = 1'b1; ctrl_d = 12'h800; rd_d = 5'd12;
    data_d = '0; data_d[4*DW +: DW] = 32'h0000_0024;
    step(1);
    check("res_ctrl", ctrl_e, 12'h800);
    check("res_rd", rd_e, 12);
    check("res_lane4", lane(4), 32'h24);

    // saturation: 20 flush edges on a 4-bit counter
    flush = 1'b1;
    step(20);
    check("sat_valid", valid_e, 0);
`ifdef PIPE_REG_DE_PERF_EN
    check("sat_flush_cnt", flush_cnt, 15);
    step(2);
    check("sat_hold", flush_cnt, 15);
    check("sat_stall_cnt", stall_cnt, 3);
`endif

    // reset mid-operation discards the instruction and counters
    flush = 1'b0; en = 1'b1; valid_d = 1'b1;
    step(1);
    check("mid_valid", valid_e, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_e, 0);
    check("mid_rst_cnt", {stall_cnt, flush_cnt}, 0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
